// File: rtl/phase_seq_pkg.sv
// Shared encodings and helpers for the phase sequencer arbiter.
// One-hot state encodings keep a single-bit upset from aliasing another legal state.
package phase_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_RUN  = 3'b010,
      ST_ERR  = 3'b100
   } state_t;

   localparam logic [1:0] PHASE_LAST = 2'd3;

   // Index width for n requesters, never below one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/phase_seq_arbiter_if.sv
// Requester/sequencer bundle: request and step strobes in, grant and phase status out.
interface phase_seq_arbiter_if #(
   parameter int NREQ = 4
);
   import phase_seq_pkg::*;

   localparam int IW = idx_w(NREQ);

   logic [NREQ-1:0] req;
   logic            adv;
   logic            clr_err;
   logic [NREQ-1:0] gnt;
   logic [1:0]      phase;
   logic            busy;
   logic            done;
   logic            err;
   logic [IW-1:0]   owner;

   modport master (
      output req, adv, clr_err,
      input  gnt, phase, busy, done, err, owner
   );

   modport slave (
      input  req, adv, clr_err,
      output gnt, phase, busy, done, err, owner
   );

endinterface

// File: rtl/phase_seq_arbiter_rr_pick.sv
// Rotating-priority picker: first set request strictly after pointer, wrapping at NREQ.
module rr_pick
   import phase_seq_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IW = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   pointer,
   output logic [IW-1:0]   winner,
   output logic            valid
);

   logic [IW-1:0] cand;

   // Scan farthest-first so the candidate closest after the pointer is written last.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      cand   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand   = IW'((int'(pointer) + k) % NREQ);
         winner = req[cand] ? cand : winner;
         valid  = valid | req[cand];
      end
   end

endmodule

// File: rtl/phase_seq_arbiter.sv
// Round-robin owner of a 4-phase sequencer with watchdog and trap-to-ERR hardening.
// All outputs come straight from flops; no input reaches an output combinationally.
module phase_seq_arbiter
   import phase_seq_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int HOLD_MAX = 8
) (
   input logic                clk,
   input logic                rst,
   phase_seq_arbiter_if.slave bus
);

   localparam int              IW       = idx_w(NREQ);
   localparam logic [7:0]      WD_TRIP  = 8'(HOLD_MAX - 1);
   localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0]   PTR_INIT = IW'(NREQ - 1);

   state_t          state_r;
   logic [1:0]      phase_r;
   logic [NREQ-1:0] gnt_r;
   logic            busy_r;
   logic            done_r;
   logic            err_r;
   logic [IW-1:0]   owner_r;
   logic [IW-1:0]   ptr_r;
   logic [7:0]      wd_r;
   logic [IW-1:0]   win_s;
   logic            win_vld_s;
   logic            owner_req_s;

   assign owner_req_s = bus.req[owner_r];

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req     (bus.req),
      .pointer (ptr_r),
      .winner  (win_s),
      .valid   (win_vld_s)
   );

   // Sequencer FSM with phase counter, watchdog and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         phase_r <= 2'd0;
         gnt_r   <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         owner_r <= '0;
         ptr_r   <= PTR_INIT;
         wd_r    <= 8'd0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               phase_r <= 2'd0;
               wd_r    <= 8'd0;
               err_r   <= 1'b0;
               if (win_vld_s) begin
                  state_r <= ST_RUN;
                  gnt_r   <= ONE_HOT0 << win_s;
                  owner_r <= win_s;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  gnt_r   <= '0;
                  busy_r  <= 1'b0;
               end
            end
            ST_RUN: begin
               // Abort outranks both a step and the watchdog trap.
               if (!owner_req_s) begin
                  state_r <= ST_IDLE;
                  gnt_r   <= '0;
                  phase_r <= 2'd0;
                  busy_r  <= 1'b0;
                  wd_r    <= 8'd0;
                  ptr_r   <= owner_r;
               end else if (bus.adv) begin
                  wd_r <= 8'd0;
                  if (phase_r == PHASE_LAST) begin
                     state_r <= ST_IDLE;
                     gnt_r   <= '0;
                     phase_r <= 2'd0;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     ptr_r   <= owner_r;
                  end else begin
                     phase_r <= phase_r + 2'd1;
                  end
               end else if (wd_r >= WD_TRIP) begin
                  state_r <= ST_ERR;
                  gnt_r   <= '0;
                  phase_r <= 2'd0;
                  busy_r  <= 1'b0;
                  err_r   <= 1'b1;
                  wd_r    <= 8'd0;
               end else begin
                  wd_r <= wd_r + 8'd1;
               end
            end
            ST_ERR: begin
               gnt_r   <= '0;
               phase_r <= 2'd0;
               busy_r  <= 1'b0;
               wd_r    <= 8'd0;
               if (bus.clr_err) begin
                  state_r <= ST_IDLE;
                  err_r   <= 1'b0;
               end else begin
                  state_r <= ST_ERR;
                  err_r   <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_ERR;
               gnt_r   <= '0;
               phase_r <= 2'd0;
               busy_r  <= 1'b0;
               err_r   <= 1'b1;
               wd_r    <= 8'd0;
            end
         endcase
      end
   end

   assign bus.gnt   = gnt_r;
   assign bus.phase = phase_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.err   = err_r;
   assign bus.owner = owner_r;

endmodule

// File: tb/tb_phase_seq_arbiter.sv
// Directed bench for phase_seq_arbiter: stimulus queues expected grant/done/err events,
// an independent negedge monitor pops and compares them as the DUT presents them.
module tb_phase_seq_arbiter;
   import phase_seq_pkg::*;

   typedef struct packed {
      logic [1:0] kind;
      logic [3:0] gnt;
      logic [1:0] owner;
   } exp_t;

   localparam logic [1:0] K_GNT  = 2'd0;
   localparam logic [1:0] K_DONE = 2'd1;
   localparam logic [1:0] K_ERR  = 2'd2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         n_checks = 0;
   int         n_fail = 0;
   exp_t       exp_q[$];
   logic [3:0] prev_gnt = 4'd0;
   logic       prev_err = 1'b0;

   phase_seq_arbiter_if #(.NREQ(4)) bus ();

   phase_seq_arbiter #(.NREQ(4), .HOLD_MAX(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] k, input logic [3:0] g, input logic [1:0] o);
      exp_t e;
      e.kind  = k;
      e.gnt   = g;
      e.owner = o;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic mon_pop(input logic [1:0] k);
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL mon_unexpected: got event kind %0d gnt=%b owner=%0d, expected no event at %0t",
                  k, bus.gnt, bus.owner, $time);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== k || (k == K_GNT && bus.gnt !== e.gnt) ||
             (k != K_ERR && bus.owner !== e.owner)) begin
            n_fail++;
            $display("FAIL mon_event: got kind=%0d gnt=%b owner=%0d, expected kind=%0d gnt=%b owner=%0d at %0t",
                     k, bus.gnt, bus.owner, e.kind, e.gnt, e.owner, $time);
         end
      end
   endtask

   // Monitor: grant rising edge, done pulse and err rising edge are scoreboard events.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) mon_pop(K_DONE);
         if (bus.gnt !== 4'd0 && prev_gnt === 4'd0) mon_pop(K_GNT);
         if (bus.err === 1'b1 && prev_err !== 1'b1) mon_pop(K_ERR);
         prev_gnt = bus.gnt;
         prev_err = bus.err;
      end
   end

   initial begin
      bus.req     = 4'd0;
      bus.adv     = 1'b0;
      bus.clr_err = 1'b0;
      tick(2);
      chk("rst_gnt", bus.gnt, 4'd0);
      chk("rst_phase", bus.phase, 2'd0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_owner", bus.owner, 2'd0);
      rst = 1'b0;

      // Single requester, full pass.
      push(K_GNT, 4'b0100, 2'd2);
      bus.req = 4'b0100;
      tick();
      chk("t1_gnt", bus.gnt, 4'b0100);
      chk("t1_owner", bus.owner, 2'd2);
      chk("t1_busy", bus.busy, 1'b1);
      chk("t1_phase0", bus.phase, 2'd0);
      bus.adv = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("t1_phase", bus.phase, 32'(i));
      end
      push(K_DONE, 4'd0, 2'd2);
      tick();
      chk("t1_done", bus.done, 1'b1);
      chk("t1_gnt_off", bus.gnt, 4'd0);
      chk("t1_phase_rst", bus.phase, 2'd0);
      chk("t1_busy_off", bus.busy, 1'b0);
      bus.req = 4'd0;
      bus.adv = 1'b0;
      tick();
      chk("t1_done_pulse", bus.done, 1'b0);

      // All requesting with adv always high, from a fresh reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int g = 0; g < 5; g++) begin
         push(K_GNT, 4'b0001 << (g % 4), 2'(g % 4));
         push(K_DONE, 4'd0, 2'(g % 4));
      end
      bus.req = 4'b1111;
      bus.adv = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         tick();
         chk("t2_done", bus.done, (k % 5 == 0) ? 1'b1 : 1'b0);
         chk("t2_gnt", bus.gnt, (k % 5 == 0) ? 4'd0 : (4'b0001 << (((k - 1) / 5) % 4)));
      end
      bus.req = 4'd0;
      bus.adv = 1'b0;
      tick();

      // Owner 1 aborts at phase 2 while stepping; pointer then sits at 1.
      push(K_GNT, 4'b0010, 2'd1);
      bus.req = 4'b0010;
      tick();
      chk("t3_gnt", bus.gnt, 4'b0010);
      bus.adv = 1'b1;
      tick(2);
      chk("t3_phase2", bus.phase, 2'd2);
      bus.req = 4'd0;
      tick();
      chk("t3_abort_gnt", bus.gnt, 4'd0);
      chk("t3_abort_phase", bus.phase, 2'd0);
      chk("t3_abort_done", bus.done, 1'b0);
      bus.adv = 1'b0;
      push(K_GNT, 4'b0001, 2'd0);
      bus.req = 4'b0011;
      tick();
      chk("t3_wrap_gnt", bus.gnt, 4'b0001);
      chk("t3_wrap_owner", bus.owner, 2'd0);
      bus.req = 4'd0;
      tick();

      // Stalled owner trips the watchdog; ERR ignores adv and leaves only via clr_err.
      push(K_GNT, 4'b0001, 2'd0);
      bus.req = 4'b0001;
      tick();
      chk("t4_gnt", bus.gnt, 4'b0001);
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("t4_no_err", bus.err, 1'b0);
         chk("t4_still_busy", bus.busy, 1'b1);
      end
      push(K_ERR, 4'd0, 2'd0);
      tick();
      chk("t4_err", bus.err, 1'b1);
      chk("t4_err_gnt", bus.gnt, 4'd0);
      chk("t4_err_busy", bus.busy, 1'b0);
      bus.adv = 1'b1;
      tick();
      chk("t4_err_hold", bus.err, 1'b1);
      chk("t4_err_phase", bus.phase, 2'd0);
      bus.adv = 1'b0;
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      chk("t4_clr_err", bus.err, 1'b0);
      chk("t4_clr_no_gnt", bus.gnt, 4'd0);
      push(K_GNT, 4'b0001, 2'd0);
      tick();
      chk("t4_regrant", bus.gnt, 4'b0001);
      bus.req = 4'd0;
      tick();

      // Illegal state encoding traps to ERR.
      push(K_ERR, 4'd0, 2'd0);
      force dut.state_r = state_t'(3'b011);
      tick();
      chk("t5_illegal_err", bus.err, 1'b1);
      chk("t5_illegal_busy", bus.busy, 1'b0);
      release dut.state_r;
      tick(2);
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      chk("t5_clr", bus.err, 1'b0);

      // Asynchronous reset mid-RUN at phase 1.
      push(K_GNT, 4'b0001, 2'd0);
      bus.req = 4'b0001;
      tick();
      bus.adv = 1'b1;
      tick();
      bus.adv = 1'b0;
      chk("t6_phase1", bus.phase, 2'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_gnt", bus.gnt, 4'd0);
      chk("t6_async_phase", bus.phase, 2'd0);
      chk("t6_async_busy", bus.busy, 1'b0);
      chk("t6_async_done", bus.done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      bus.req = 4'd0;
      tick(2);
      chk("t6_idle_gnt", bus.gnt, 4'd0);

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending events, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
